// File: rtl/count_display_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 3-digit
// multiplexed common-anode 7-segment display with optional leading-zero blanking.
module count_display_driver #(
   parameter int unsigned REFRESH_DIV   = 16,
   parameter bit          BLANK_LEADING = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  count,
   output logic [11:0] bcd,
   output logic        bcd_valid,
   output logic [2:0]  an,
   output logic [6:0]  seg
);

   localparam int unsigned REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } conv_state_t;

   conv_state_t  state;
   logic [7:0]   shreg;
   logic [11:0]  scratch;
   logic [11:0]  scratch_adj;
   logic [2:0]   iter;

   logic [REF_W-1:0] refresh_cnt;
   logic [1:0]       digit_idx;

   logic [3:0]  hundreds;
   logic [3:0]  tens;
   logic [3:0]  ones;
   logic [3:0]  digit_nib;
   logic [2:0]  an_sel;
   logic        slot_blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Add-3 correction on every scratch nibble >= 5, applied before each shift.
   always_comb begin
      scratch_adj = scratch;
      for (int unsigned i = 0; i < 3; i++) begin
         if (scratch[i*4 +: 4] >= 4'd5)
            scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         scratch   <= '0;
         iter      <= '0;
         bcd       <= '0;
         bcd_valid <= 1'b0;
      end else begin
         bcd_valid <= 1'b0;
         case (state)
            IDLE: begin
               shreg   <= count;
               scratch <= '0;
               iter    <= '0;
               state   <= SHIFT;
            end
            SHIFT: begin
               {scratch, shreg} <= {scratch_adj[10:0], shreg, 1'b0};
               iter <= iter + 3'd1;
               if (iter == 3'd7)
                  state <= DONE;
            end
            DONE: begin
               bcd       <= scratch;
               bcd_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
      end else if (refresh_cnt == REF_LAST) begin
         refresh_cnt <= '0;
         digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   assign hundreds = bcd[11:8];
   assign tens     = bcd[7:4];
   assign ones     = bcd[3:0];

   // Display reads only the registered bcd, never the in-flight scratch.
   always_comb begin
      an_sel     = 3'b111;
      digit_nib  = ones;
      slot_blank = 1'b1;
      case (digit_idx)
         2'd0: begin
            an_sel     = 3'b110;
            digit_nib  = ones;
            slot_blank = 1'b0;
         end
         2'd1: begin
            an_sel     = 3'b101;
            digit_nib  = tens;
            slot_blank = BLANK_LEADING && (hundreds == 4'd0) && (tens == 4'd0);
         end
         2'd2: begin
            an_sel     = 3'b011;
            digit_nib  = hundreds;
            slot_blank = BLANK_LEADING && (hundreds == 4'd0);
         end
         default: begin
            an_sel     = 3'b111;
            digit_nib  = ones;
            slot_blank = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= 3'b111;
         seg <= 7'b1111111;
      end else if (slot_blank) begin
         an  <= 3'b111;
         seg <= 7'b1111111;
      end else begin
         an  <= an_sel;
         seg <= seg_decode(digit_nib);
      end
   end

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver: two instances (blanking on/off)
// sharing clock, reset and count.
module tb_count_display_driver;

   localparam int RD = 4;

   logic        clk;
   logic        rst_n;
   logic [7:0]  count;
   logic [11:0] bcd_b, bcd_nb;
   logic        valid_b, valid_nb;
   logic [2:0]  an_b, an_nb;
   logic [6:0]  seg_b, seg_nb;

   int checks = 0;
   int errors = 0;
   int glitches = 0;

   logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   typedef struct {
      logic [7:0]  cnt;
      logic [11:0] exp_bcd;
      logic [2:0]  lit;   // {hundreds, tens, ones} slots lit with blanking on
   } vec_t;

   vec_t vecs [8];

   count_display_driver #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .count(count), .bcd(bcd_b),
      .bcd_valid(valid_b), .an(an_b), .seg(seg_b));

   count_display_driver #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .count(count), .bcd(bcd_nb),
      .bcd_valid(valid_nb), .an(an_nb), .seg(seg_nb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_valid();
      int n;
      logic [11:0] prev;
      n = 0;
      prev = bcd_b;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (!valid_b && bcd_b !== prev) glitches++;
      end while (!valid_b && n < 40);
      if (!valid_b) begin
         checks++;
         errors++;
         $display("FAIL wait_valid: no bcd_valid within %0d clocks", n);
      end
   endtask

   task automatic measure_latency(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!valid_b && n < 40);
   endtask

   // Sample 3*RD consecutive cycles; every slot appears exactly RD times.
   task automatic scan(input bit nb, input logic [11:0] v, input logic [2:0] lit);
      int c110, c101, c011, c111, bad;
      logic [2:0] a;
      logic [6:0] s;
      c110 = 0; c101 = 0; c011 = 0; c111 = 0; bad = 0;
      repeat (3 * RD) begin
         @(posedge clk);
         #1;
         a = nb ? an_nb : an_b;
         s = nb ? seg_nb : seg_b;
         case (a)
            3'b110: begin c110++; if (s !== segtab[v[3:0]]) bad++; end
            3'b101: begin c101++; if (s !== segtab[v[7:4]]) bad++; end
            3'b011: begin c011++; if (s !== segtab[v[11:8]]) bad++; end
            3'b111: begin c111++; if (s !== 7'b1111111) bad++; end
            default: bad++;
         endcase
      end
      chk(nb ? "scan_nb_ones" : "scan_ones", c110, lit[0] ? RD : 0);
      chk(nb ? "scan_nb_tens" : "scan_tens", c101, lit[1] ? RD : 0);
      chk(nb ? "scan_nb_hund" : "scan_hund", c011, lit[2] ? RD : 0);
      chk(nb ? "scan_nb_blank" : "scan_blank", c111,
          (lit[1] ? 0 : RD) + (lit[2] ? 0 : RD));
      chk(nb ? "scan_nb_seg" : "scan_seg", bad, 0);
   endtask

   initial begin
      int lat;
      int n, run;
      logic [2:0] prev_an;

      vecs[0] = '{8'd0,   12'h000, 3'b001};
      vecs[1] = '{8'd255, 12'h255, 3'b111};
      vecs[2] = '{8'd137, 12'h137, 3'b111};
      vecs[3] = '{8'd5,   12'h005, 3'b001};
      vecs[4] = '{8'd40,  12'h040, 3'b011};
      vecs[5] = '{8'd100, 12'h100, 3'b111};
      vecs[6] = '{8'd9,   12'h009, 3'b001};
      vecs[7] = '{8'd99,  12'h099, 3'b011};

      rst_n = 1'b0;
      count = 8'd0;
      #12;
      chk("rst_bcd", bcd_b, 12'h000);
      chk("rst_valid", valid_b, 1'b0);
      chk("rst_an", an_b, 3'b111);
      chk("rst_seg", seg_b, 7'b1111111);

      @(posedge clk);
      #1 rst_n = 1'b1;
      measure_latency(lat);
      chk("first_valid_latency", lat, 10);
      chk("first_bcd", bcd_b, 12'h000);
      scan(1'b0, 12'h000, 3'b001);

      for (int i = 0; i < 8; i++) begin
         wait_valid();
         count = vecs[i].cnt;
         wait_valid();
         chk("vec_bcd", bcd_b, vecs[i].exp_bcd);
         chk("vec_bcd_nb", bcd_nb, vecs[i].exp_bcd);
         scan(1'b0, vecs[i].exp_bcd, vecs[i].lit);
         scan(1'b1, vecs[i].exp_bcd, 3'b111);
      end

      // Sample of 3, then change to 200 two clocks after the sampling edge.
      wait_valid();
      count = 8'd3;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1 count = 8'd200;
      wait_valid();
      chk("late_change_first", bcd_b, 12'h003);
      wait_valid();
      chk("late_change_second", bcd_b, 12'h200);

      // Slot order and duration with 137 on display.
      count = 8'd137;
      wait_valid();
      wait_valid();
      n = 0;
      prev_an = an_b;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (an_b == 3'b110 && prev_an != 3'b110) break;
         prev_an = an_b;
      end while (n < 4 * RD);
      chk("order_found_ones", an_b, 3'b110);
      run = 1;
      repeat (RD - 1) begin @(posedge clk); #1; if (an_b == 3'b110) run++; end
      chk("order_ones_len", run, RD);
      run = 0;
      repeat (RD) begin @(posedge clk); #1; if (an_b == 3'b101 && seg_b == 7'b0110000) run++; end
      chk("order_tens_len", run, RD);
      run = 0;
      repeat (RD) begin @(posedge clk); #1; if (an_b == 3'b011 && seg_b == 7'b1111001) run++; end
      chk("order_hund_len", run, RD);
      @(posedge clk);
      #1;
      chk("order_wrap_ones", {an_b, seg_b}, {3'b110, 7'b1111000});

      // Asynchronous reset in the middle of SHIFT.
      wait_valid();
      chk("pre_reset_bcd", bcd_b, 12'h137);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_bcd", bcd_b, 12'h000);
      chk("async_rst_an", an_b, 3'b111);
      chk("async_rst_seg", seg_b, 7'b1111111);
      chk("async_rst_valid", valid_b, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      measure_latency(lat);
      chk("restart_latency", lat, 10);
      chk("restart_bcd", bcd_b, 12'h137);

      chk("bcd_glitches", glitches, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
Downstream consumer of the 8-bit up/down counter value. It converts the `count` bus to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto a 3-digit common-anode 7-segment display with leading-zero blanking. It also exports the registered BCD value with a one-cycle update strobe for other consumers.

Parameters:
REFRESH_DIV, 16, clocks each digit stays lit. Legal range is ≥2; the board build overrides it to 50000.
BLANK_LEADING, 1, 1 = suppress leading zeros on hundreds/tens; 0 = always show all three digits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
count  input  8  unsigned binary value from the up/down counter.
bcd  output  12  registered BCD {hundreds, tens, ones}; hundreds ≤ 2.
bcd_valid  output  1  one-cycle pulse when `bcd` is updated.
an  output  3  digit enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (async assert, sync release by `clk`) clears everything:
  - bcd=12'h000, bcd_valid=0, an=3'b111, seg=7'b1111111.
  - Converter FSM goes to IDLE; refresh counter=0; digit index=0.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE (1 cycle): load `count` into an 8-bit shift register, clear the 12-bit scratch BCD, clear the iteration counter. Go to SHIFT.
  - SHIFT (exactly 8 cycles): each cycle, add 3 to every scratch nibble ≥5, then shift {scratch, shift-reg} left one bit. After the 8th iteration, go to DONE.
  - DONE (1 cycle): copy scratch to `bcd`, set bcd_valid=1 for this cycle only, return to IDLE.
- Conversion period is 10 clocks, free-running. `bcd` reflects the `count` sampled at the IDLE edge, and updates 9 clocks later.
- `count` changes during SHIFT/DONE are ignored until the next IDLE sample. No glitch on `bcd` between updates.
- `bcd` is updated every period even if the value is unchanged; bcd_valid still pulses.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, digit index advances 0→1→2→0.
- an/seg are registered and change one clock after the digit index changes.
- Digit select: index 0 → an=3'b110, ones nibble. Index 1 → an=3'b101, tens nibble. Index 2 → an=3'b011, hundreds nibble.
- Blanking (BLANK_LEADING=1): a blanked slot drives an=3'b111 and seg=7'b1111111.
  - Hundreds slot is blanked when hundreds==0.
  - Tens slot is blanked when hundreds==0 and tens==0.
  - Ones is never blanked, so value 0 displays "0".
- Display always uses the registered `bcd`. It never uses the in-flight scratch.
- Segment decode (active-low):
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001
  - 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000
  - Codes A–F cannot occur; decode them as all-off.
- Up/down counter wrap-around (255↔0) needs no special handling. Each sample converts independently.
- Reset mid-conversion or mid-scan aborts immediately. After release, the first IDLE occurs on the first `clk` edge, and the first bcd_valid pulse follows 9 clocks later.

Test Plan:
- Hold count=8'd0 after reset → first bcd_valid exactly 10 clocks after release with bcd=12'h000. Scan shows ones slot seg=1000000/an=110 and blanks the tens and hundreds slots (an=111).
- count=8'd255 → bcd=12'h255 after next bcd_valid. Over 3·REFRESH_DIV clocks, observe an=110/seg=0010010, an=101/seg=0010010, an=011/seg=0100100.
- count=8'd137 → bcd=12'h137. Digit order is ones(7)→tens(3)→hundreds(1); each slot lasts exactly REFRESH_DIV clocks.
- count=8'd5 with BLANK_LEADING=1 → only the ones slot lit (seg=0010010). Rerun with BLANK_LEADING=0 → tens and hundreds show seg=1000000.
- Change count 3→200 two clocks after a sampling edge → next bcd_valid still reports 12'h003; the following one reports 12'h200.
- Assert rst_n low during SHIFT with bcd=12'h137 → bcd=000, an=111, seg=1111111 immediately, without waiting for a clock. After release, conversion restarts cleanly with the 10-clock latency.
